// File: rtl/data_memory_port.sv
// data_memory_port: big-endian byte-addressed data memory responder for the MEM stage.
// Multi-cycle access FSM (IDLE -> WAIT -> DONE); Busy stalls the pipeline, Ready pulses on completion.
// Optional alignment fault detection is enabled by defining DM_ALIGN_CHECK_EN.
module data_memory_port #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              MEM_load_instr,
  input  logic              MEM_Read_Write,
  input  logic [1:0]        MEM_size_dm,
  input  logic              MEM_SE_dm,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              Ready,
  output logic              Busy,
  output logic              Misaligned
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              accept;
  logic              enter_done;

  // Request captured at accept
  logic [ADDR_W-1:0] addr_reg;
  logic              rw_reg;
  logic [1:0]        size_reg;
  logic              se_reg;
  logic [31:0]       data_reg;

  // Effective request: with zero wait states DONE is entered straight from the
  // accept edge, so the live inputs must be used instead of the captured copy.
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_rw;
  logic [1:0]        eff_size;
  logic              eff_se;
  logic [31:0]       eff_data;

  logic              fault_eff;
  logic              fault_cap;

  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] lane_addr  [4];
  logic [7:0]        lane_wdata [4];
  logic [7:0]        lane_rdata [4];
  logic [3:0]        lane_en;
  logic [31:0]       load_result;

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MEM_load_instr) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES - 1);
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_done = (state_next == DONE) && (state_reg != DONE);

  // State register; reset aborts any access in flight
  always_ff @(posedge Clk) begin
    if (R) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request on the accept edge
  always_ff @(posedge Clk) begin
    if (R) begin
      addr_reg <= '0;
      rw_reg   <= 1'b0;
      size_reg <= 2'b00;
      se_reg   <= 1'b0;
      data_reg <= 32'h0;
    end else if (accept) begin
      addr_reg <= Address;
      rw_reg   <= MEM_Read_Write;
      size_reg <= MEM_size_dm;
      se_reg   <= MEM_SE_dm;
      data_reg <= DataIn;
    end
  end

  assign eff_addr = accept ? Address        : addr_reg;
  assign eff_rw   = accept ? MEM_Read_Write : rw_reg;
  assign eff_size = accept ? MEM_size_dm    : size_reg;
  assign eff_se   = accept ? MEM_SE_dm      : se_reg;
  assign eff_data = accept ? DataIn         : data_reg;

`ifdef DM_ALIGN_CHECK_EN
  // Halfword needs A[0]=0, word (size 10 or 11) needs A[1:0]=00
  function automatic logic align_fault(input logic [1:0] size, input logic [1:0] a_lo);
    return (size == 2'b01 && a_lo[0]) || (size[1] && a_lo != 2'b00);
  endfunction
  assign fault_eff = align_fault(eff_size, eff_addr[1:0]);
  assign fault_cap = align_fault(size_reg, addr_reg[1:0]);
`else
  assign fault_eff = 1'b0;
  assign fault_cap = 1'b0;
`endif

  // Byte lanes: lane 0 is the MSB at address A, higher lanes follow with wrap
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi]  = eff_addr + ADDR_W'(gi);
    assign lane_en[gi]    = (gi == 0) || ((gi == 1) && (eff_size != 2'b00)) || eff_size[1];
    assign lane_wdata[gi] = (eff_size == 2'b00) ? eff_data[7:0] :
                            (eff_size == 2'b01) ? ((gi == 0) ? eff_data[15:8] : eff_data[7:0]) :
                                                  eff_data[31-8*gi -: 8];
    assign lane_rdata[gi] = mem[lane_addr[gi]];
  end

  // Load data formatting with sign/zero extension
  always_comb begin
    load_result = 32'h0;
    case (eff_size)
      2'b00:   load_result = {{24{eff_se & lane_rdata[0][7]}}, lane_rdata[0]};
      2'b01:   load_result = {{16{eff_se & lane_rdata[0][7]}}, lane_rdata[0], lane_rdata[1]};
      default: load_result = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
    endcase
  end

  // Store commit on the edge entering DONE; contents survive reset
  always_ff @(posedge Clk) begin
    if (!R && enter_done && eff_rw && !fault_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[lane_addr[i]] <= lane_wdata[i];
        end
      end
    end
  end

  // Load result register, held across stores and faulted accesses
  always_ff @(posedge Clk) begin
    if (R) begin
      DataOut <= 32'h0;
    end else if (enter_done && !eff_rw && !fault_eff) begin
      DataOut <= load_result;
    end
  end

  assign Ready      = (state_reg == DONE);
  assign Busy       = !R && (((state_reg == IDLE) && MEM_load_instr) || (state_reg == WAIT));
  assign Misaligned = Ready && fault_cap;

endmodule
